pipe_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the five-stage MIPS pipeline.
- Drives the enable and flush controls of the PC and the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB), which are built from D_FF-based 32-bit register banks.
- Resolves three hazard sources in a fixed priority:
  - data-memory wait (freeze);
  - taken-branch/jump redirect (squash);
  - load-use dependency (bubble).
- Keeps saturating stall and flush counters for performance debug.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 12 +
 rtl/pipe_hazard_ctrl_if.sv | 28 ++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 79 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         DEF_CNT_W = 32;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the pipeline and the stage enable/flush controls back to it.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic [REG_ADDR_W-1:0] id_rs, id_rt, ex_rt;
  logic                  id_uses_rs, id_uses_rt;
  logic                  ex_mem_read, ex_reg_write;
  logic                  redirect, mem_busy;
  logic                  pc_en, if_id_en, if_id_flush;
  logic                  id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
  logic                  frozen;
  logic [CNT_W-1:0]      stall_cnt, flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write,
           ex_rt, redirect, mem_busy,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_en, frozen, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write,
           ex_rt, redirect, mem_busy,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_en, frozen, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Performance counter that sticks at all-ones instead of wrapping.
module sat_counter
  import hazard_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: memory freeze > redirect squash > load-use bubble.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = DEF_CNT_W
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);

  state_e state_q, state_d;
  logic   pend_q, pend_d;
  logic   luh, stall_inc, flush_inc;

  assign luh = hz.ex_mem_read && hz.ex_reg_write &&
               (hz.ex_rt != REG_ADDR_W'(REG_ZERO)) &&
               ((hz.id_uses_rs && hz.id_rs == hz.ex_rt) ||
                (hz.id_uses_rt && hz.id_rt == hz.ex_rt));

  assign hz.frozen = (state_q == MEM_WAIT);

  always_comb begin
    state_d        = RUN;
    pend_d         = pend_q;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    hz.pc_en       = 1'b0;
    hz.if_id_en    = 1'b0;
    hz.if_id_flush = 1'b0;
    hz.id_ex_en    = 1'b0;
    hz.id_ex_flush = 1'b0;
    hz.ex_mem_en   = 1'b0;
    hz.mem_wb_en   = 1'b0;
    // Outputs stay quiet while reset is held, so the stage registers hold.
    if (!reset) begin
      if (hz.mem_busy) begin
        state_d   = MEM_WAIT;
        stall_inc = 1'b1;
        if (hz.redirect) pend_d = 1'b1;
      end else if (hz.redirect || pend_q) begin
        // Squash wins over load-use: the dependent instruction is discarded anyway.
        {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en} = '1;
        hz.if_id_flush = 1'b1;
        hz.id_ex_flush = 1'b1;
        pend_d         = 1'b0;
        flush_inc      = 1'b1;
      end else if (luh) begin
        hz.id_ex_en    = 1'b1;
        hz.id_ex_flush = 1'b1;
        hz.ex_mem_en   = 1'b1;
        hz.mem_wb_en   = 1'b1;
        stall_inc      = 1'b1;
      end else begin
        {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en} = '1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(stall_inc), .count(hz.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(flush_inc), .count(hz.flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic.
module tb_pipe_hazard_ctrl;
  localparam int AW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic          ex_mem_en, mem_wb_en, frozen;
    logic [CW-1:0] stall_cnt, flush_cnt;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(CW)) hz ();

  pipe_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .hz(hz)
  );

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Reference model state: are we waiting on memory, is a redirect owed, counts.
  bit m_waiting, m_owed;
  int m_stalls, m_flushes;

  task automatic drv(input bit rst, input int rs, input int rt, input bit urs,
                     input bit urt, input bit mr, input bit rw, input int ert,
                     input bit rd, input bit mb, input string tag);
    obs_t e;
    bit   dep;
    @(negedge clk);
    reset           = rst;
    hz.id_rs        = AW'(rs);
    hz.id_rt        = AW'(rt);
    hz.id_uses_rs   = urs;
    hz.id_uses_rt   = urt;
    hz.ex_mem_read  = mr;
    hz.ex_reg_write = rw;
    hz.ex_rt        = AW'(ert);
    hz.redirect     = rd;
    hz.mem_busy     = mb;
    e = '0;
    if (rst) begin
      m_waiting = 0; m_owed = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      dep = mr && rw && ert != 0 && ((urs && rs == ert) || (urt && rt == ert));
      e.frozen    = m_waiting;
      e.stall_cnt = CW'(m_stalls);
      e.flush_cnt = CW'(m_flushes);
      if (mb) begin
        m_waiting = 1;
        if (rd) m_owed = 1;
        if (m_stalls < CMAX) m_stalls++;
      end else begin
        m_waiting = 0;
        if (rd || m_owed) begin
          {e.pc_en, e.if_id_en, e.id_ex_en, e.ex_mem_en, e.mem_wb_en} = '1;
          e.if_id_flush = 1; e.id_ex_flush = 1;
          m_owed = 0;
          if (m_flushes < CMAX) m_flushes++;
        end else if (dep) begin
          e.id_ex_en = 1; e.id_ex_flush = 1; e.ex_mem_en = 1; e.mem_wb_en = 1;
          if (m_stalls < CMAX) m_stalls++;
        end else begin
          {e.pc_en, e.if_id_en, e.id_ex_en, e.ex_mem_en, e.mem_wb_en} = '1;
        end
      end
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic idle(input string tag);
    drv(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  // Monitor: outputs are combinational, so every cycle presents one observation.
  initial begin
    obs_t  a, e;
    string t;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a.pc_en = hz.pc_en;         a.if_id_en = hz.if_id_en;
        a.if_id_flush = hz.if_id_flush; a.id_ex_en = hz.id_ex_en;
        a.id_ex_flush = hz.id_ex_flush; a.ex_mem_en = hz.ex_mem_en;
        a.mem_wb_en = hz.mem_wb_en; a.frozen = hz.frozen;
        a.stall_cnt = hz.stall_cnt; a.flush_cnt = hz.flush_cnt;
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got pc=%b ifid=%b/%b idex=%b/%b exm=%b mwb=%b frz=%b st=%0d fl=%0d, want pc=%b ifid=%b/%b idex=%b/%b exm=%b mwb=%b frz=%b st=%0d fl=%0d",
                   t, a.pc_en, a.if_id_en, a.if_id_flush, a.id_ex_en, a.id_ex_flush,
                   a.ex_mem_en, a.mem_wb_en, a.frozen, a.stall_cnt, a.flush_cnt,
                   e.pc_en, e.if_id_en, e.if_id_flush, e.id_ex_en, e.id_ex_flush,
                   e.ex_mem_en, e.mem_wb_en, e.frozen, e.stall_cnt, e.flush_cnt);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    hz.id_rs = '0; hz.id_rt = '0; hz.ex_rt = '0;
    hz.id_uses_rs = 0; hz.id_uses_rt = 0; hz.ex_mem_read = 0;
    hz.ex_reg_write = 0; hz.redirect = 0; hz.mem_busy = 0;

    drv(1, 8, 0, 1, 0, 1, 1, 8, 0, 0, "reset_state");
    idle("run_after_reset");
    drv(0, 8, 0, 1, 0, 1, 1, 8, 0, 0, "load_use");
    idle("after_bubble");
    drv(0, 0, 0, 1, 1, 1, 1, 0, 0, 0, "zero_exempt");
    drv(0, 3, 9, 0, 1, 1, 1, 9, 0, 0, "load_use_rt");
    drv(0, 9, 0, 0, 1, 1, 1, 9, 0, 0, "rs_unused_no_stall");
    drv(0, 8, 0, 1, 0, 1, 1, 8, 1, 0, "redirect_over_luh");

    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset2");
    drv(0, 1, 2, 0, 0, 0, 0, 0, 0, 1, "freeze1");
    drv(0, 1, 2, 0, 0, 0, 0, 0, 1, 1, "freeze2_redirect");
    drv(0, 1, 2, 0, 0, 0, 0, 0, 0, 1, "freeze3");
    idle("freeze_exit_flush");
    idle("no_second_flush");
    drv(0, 1, 2, 0, 0, 0, 0, 0, 1, 1, "double_redir_a");
    drv(0, 1, 2, 0, 0, 0, 0, 0, 1, 1, "double_redir_b");
    idle("double_redir_single_flush");
    idle("double_redir_after");

    drv(0, 1, 2, 0, 0, 0, 0, 0, 0, 1, "pend_freeze1");
    drv(0, 1, 2, 0, 0, 0, 0, 0, 1, 1, "pend_freeze2");
    drv(1, 1, 2, 0, 0, 0, 0, 0, 0, 1, "reset_mid_freeze");
    idle("release_no_flush");
    idle("release_steady");

    for (int i = 0; i < CMAX + 3; i++)
      drv(0, 4, 0, 1, 0, 1, 1, 4, 0, 0, "stall_saturate");
    for (int i = 0; i < CMAX + 3; i++)
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "flush_saturate");

    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset3");
    for (int i = 0; i < 600; i++) begin
      drv($urandom_range(59) == 0,
          int'($urandom_range(3)), int'($urandom_range(3)),
          $urandom_range(1), $urandom_range(1),
          $urandom_range(1), $urandom_range(3) != 0,
          int'($urandom_range(3)),
          $urandom_range(4) == 0, $urandom_range(3) == 0, "random");
    end

    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d observations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want stimulus complete");
    $fatal(1, "watchdog");
  end

endmodule
